channel_layout_engine: RTL
==========================

// Module: channel_layout_engine
// PURPOSE
//  Sequential successor of the combinational row-to-channel mapper in the VGA scope path. On each
//  frame_start it snapshots channel_enable and computes an exact channel height by serial division.
//  It then builds a visible-index-to-channel table. During active video it tracks channel
//  boundaries incrementally per row (no per-pixel divide or multiply) and drives registered
//  per-row channel info to the trace renderer.
// PARAMETERS
//  MAX_CHAN_COUNT  10   number of channels; 1..16
//  VER_RES         480  visible rows per frame
//  OFFSET          0    rows reserved at top (header); 0..VER_RES-1
//  (derived) RW = $clog2(VER_RES+1), CW = max(1,$clog2(MAX_CHAN_COUNT))
// PORTS
//  clk             in   1    pixel clock
//  reset_n         in   1    asynchronous, active-low reset
//  channel_enable  in   MAX_CHAN_COUNT  enable per channel; sampled only at frame_start
//  frame_start     in   1    one-cycle pulse at start of vertical blanking
//  row_valid       in   1    one-cycle pulse per new visible row
//  pixel_row       in   RW   row number; valid with row_valid
//  layout_ready    out  1    layout for current frame computed
//  is_channel      out  1    current row belongs to a channel
//  channel_number  out  CW   physical channel index of current row
//  channel_height  out  RW   rows per channel = (VER_RES-OFFSET)/count, floor
//  channel_offset  out  RW   first row of current channel
//  channel_count   out  CW+1 number of enabled channels (snapshot)
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; table cleared. Async assert; release is sync to clk.
//  FSM: IDLE -frame_start-> SNAP -> DIV -> MAP -> READY.
//   Any frame_start in any state restarts at SNAP (abort).
//  SNAP (1 cyc): latch en_q=channel_enable; count=popcount(en_q); layout_ready<=0.
//   If count==0: height=0 and go directly to READY.
//  DIV (RW cyc): restoring division (VER_RES-OFFSET)/count, 1 quotient bit/cycle. Quotient->height.
//   Remainder rows are unused.
//  MAP (MAX_CHAN_COUNT cyc): scan k=0..MAX-1; if en_q[k], write table[n]=k and n++.
//  READY: layout_ready=1. Total layout latency = 2+RW+MAX_CHAN_COUNT cycles from frame_start.
//   This must fit in vertical blanking; row_valid is ignored while layout_ready=0.
//  Row tracker reset at frame_start: vis=0, start=OFFSET, next=OFFSET+height.
//  On row_valid (layout_ready=1), outputs update exactly 1 cycle later:
//   - pixel_row<OFFSET: is_channel=0.
//   - pixel_row==next and vis<count-1: vis++, start=next, next+=height. Same cycle's outputs use the new vis.
//   - pixel_row>=OFFSET+count*height (remainder rows) or count==0: is_channel=0.
//   - otherwise is_channel=1, channel_number=table[vis], channel_offset=start.
//  Outputs hold between row_valid pulses. channel_height and channel_count are stable from READY to the next SNAP.
//  Rows arrive monotonically increasing within a frame. A non-monotonic row leaves the tracker state unchanged.
//   is_channel is still computed against start/next.
//  channel_enable changes mid-frame have no effect until the next frame_start.
//  Boundary rule: row == start of channel j maps to channel j (strict >= boundary).
// TESTING
//  1 VER_RES=480,OFFSET=0, en='b100101, frame_start -> count=3, height=160, ready after 2+9+10 cyc.
//    Then rows 0,159->ch0 off0; 160,319->ch2 off160; 320,479->ch5 off320.
//  2 en=7 channels -> height=68; row 475->ch idx table[6], off 408; rows 476..479 -> is_channel=0.
//  3 OFFSET=40, en='b1 -> height=440; row 39 -> is_channel=0; row 40 -> ch0 off40; row 479 -> ch0.
//  4 en=0 -> count=0, height=0, layout_ready=1 after 1 cyc, every row is_channel=0.
//  5 change en mid-frame -> mapping unchanged until next frame_start.
//    frame_start during DIV -> restart, layout_ready stays 0 until the new layout completes.
//  6 reset_n low mid-DIV and mid-frame -> outputs 0 asynchronously.
//    After release, nothing is valid until the next frame_start + latency.

Source files
------------

// File: rtl/channel_layout_engine_if.sv
// Bus between the scan-timing source and the channel layout engine.
interface channel_layout_engine_if #(
  parameter int MAX_CHAN_COUNT = 10,
  parameter int VER_RES        = 480
);
  localparam int RW = $clog2(VER_RES + 1);
  localparam int CW = (MAX_CHAN_COUNT > 1) ? $clog2(MAX_CHAN_COUNT) : 1;

  logic [MAX_CHAN_COUNT-1:0] channel_enable;
  logic                      frame_start;
  logic                      row_valid;
  logic [RW-1:0]             pixel_row;
  logic                      layout_ready;
  logic                      is_channel;
  logic [CW-1:0]             channel_number;
  logic [RW-1:0]             channel_height;
  logic [RW-1:0]             channel_offset;
  logic [CW:0]               channel_count;

  modport slave (
    input  channel_enable, frame_start, row_valid, pixel_row,
    output layout_ready, is_channel, channel_number, channel_height,
           channel_offset, channel_count
  );

  modport master (
    output channel_enable, frame_start, row_valid, pixel_row,
    input  layout_ready, is_channel, channel_number, channel_height,
           channel_offset, channel_count
  );
endinterface

// File: rtl/channel_layout_engine.sv
// Per-frame channel layout: snapshot enables, serial divide for channel
// height, build visible-index -> channel table, then track channel
// boundaries row by row with adds and compares only.
module channel_layout_engine #(
  parameter int MAX_CHAN_COUNT = 10,
  parameter int VER_RES        = 480,
  parameter int OFFSET         = 0
) (
  input logic                    clk,
  input logic                    reset_n,
  channel_layout_engine_if.slave bus
);
  localparam int RW = $clog2(VER_RES + 1);
  localparam int CW = (MAX_CHAN_COUNT > 1) ? $clog2(MAX_CHAN_COUNT) : 1;
  localparam logic [RW-1:0] DIVIDEND = RW'(VER_RES - OFFSET);
  localparam logic [RW-1:0] ROW0     = RW'(OFFSET);

  typedef enum logic [2:0] {IDLE, SNAP, DIV, MAP, READY} state_t;

  state_t                    state;
  logic [MAX_CHAN_COUNT-1:0] en_q;
  logic [CW-1:0]             tbl [MAX_CHAN_COUNT];
  logic [RW:0]               rem;
  logic [RW-1:0]             quo, step;
  logic [CW-1:0]             k, n, vis;
  logic [RW-1:0]             start, next, last_row;
  logic                      have_row;

  logic [CW:0]               pop;
  logic [RW:0]               trial;
  logic                      ge;
  logic [RW-1:0]             quo_nxt;
  logic                      mono, adv, ic;
  logic [CW-1:0]             vis_e;
  logic [RW-1:0]             start_e, next_e;

  // Enable popcount and one restoring-division step (dividend shifts out of quo's MSB).
  always_comb begin
    pop = '0;
    for (int i = 0; i < MAX_CHAN_COUNT; i++) pop = pop + (CW+1)'(en_q[i]);
    trial   = {rem[RW-1:0], quo[RW-1]};
    ge      = trial >= (RW+1)'(bus.channel_count);
    quo_nxt = {quo[RW-2:0], ge};
  end

  // Row tracker next state: advance to the next channel when the row hits its first line;
  // the last channel never advances, so rows past it fall outside [start,next) as remainder.
  always_comb begin
    mono    = !have_row || (bus.pixel_row >= last_row);
    adv     = mono && (bus.pixel_row == next) &&
              (((CW+1)'(vis) + (CW+1)'(1)) < bus.channel_count);
    vis_e   = adv ? vis + CW'(1) : vis;
    start_e = adv ? next : start;
    next_e  = adv ? next + bus.channel_height : next;
    ic      = (bus.channel_count != '0) && (bus.pixel_row >= start_e) &&
              (bus.pixel_row < next_e);
  end

  // Layout FSM plus row tracker; frame_start aborts whatever is in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state              <= IDLE;
      en_q               <= '0;
      rem                <= '0;
      quo                <= '0;
      step               <= '0;
      k                  <= '0;
      n                  <= '0;
      vis                <= '0;
      start              <= '0;
      next               <= '0;
      last_row           <= '0;
      have_row           <= 1'b0;
      bus.layout_ready   <= 1'b0;
      bus.is_channel     <= 1'b0;
      bus.channel_number <= '0;
      bus.channel_height <= '0;
      bus.channel_offset <= '0;
      bus.channel_count  <= '0;
      for (int i = 0; i < MAX_CHAN_COUNT; i++) tbl[i] <= '0;
    end else if (bus.frame_start) begin
      state            <= SNAP;
      en_q             <= bus.channel_enable;
      bus.layout_ready <= 1'b0;
      vis              <= '0;
      have_row         <= 1'b0;
    end else begin
      case (state)
        SNAP: begin
          bus.channel_count <= pop;
          rem  <= '0;
          quo  <= DIVIDEND;
          step <= '0;
          k    <= '0;
          n    <= '0;
          if (pop == '0) begin
            bus.channel_height <= '0;
            bus.layout_ready   <= 1'b1;
            start              <= ROW0;
            next               <= ROW0;
            state              <= READY;
          end else begin
            state <= DIV;
          end
        end
        DIV: begin
          rem  <= ge ? trial - (RW+1)'(bus.channel_count) : trial;
          quo  <= quo_nxt;
          step <= step + RW'(1);
          if (step == RW'(RW - 1)) begin
            bus.channel_height <= quo_nxt;
            state              <= MAP;
          end
        end
        MAP: begin
          if (en_q[k]) begin
            tbl[n] <= k;
            n      <= n + CW'(1);
          end
          k <= k + CW'(1);
          if (k == CW'(MAX_CHAN_COUNT - 1)) begin
            bus.layout_ready <= 1'b1;
            start            <= ROW0;
            next             <= ROW0 + bus.channel_height;
            state            <= READY;
          end
        end
        READY: begin
          if (bus.row_valid) begin
            if (mono) begin
              vis      <= vis_e;
              start    <= start_e;
              next     <= next_e;
              last_row <= bus.pixel_row;
              have_row <= 1'b1;
            end
            bus.is_channel <= ic;
            if (ic) begin
              bus.channel_number <= tbl[vis_e];
              bus.channel_offset <= start_e;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule
